// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
//   Shared definitions for the pipelined adder/subtractor:
//   - slice_w()      : width of one pipeline slice (WIDTH / STAGES)
//   - OP_ADD/OP_SUB  : encoding of the Sub input
//   - addsub_flags_t : result flags registered alongside C
// -----------------------------------------------------------------------------
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic cout;   // carry out (add) / borrow out (sub)
        logic ovf;    // signed overflow
        logic zero;   // result == 0
    } addsub_flags_t;

    function automatic int slice_w(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// -----------------------------------------------------------------------------
// pipelined_addsub_if
//   Operand/result bus of the pipelined adder/subtractor.
//   Input side : in_valid, in_ready, A, B, Cin, Sub
//   Output side: out_valid, out_ready, C, Cout, Ovf, Zero
//   master modport = operand source / result consumer, slave = the adder.
//
//   Handshake: a transfer happens on a rising clock edge where valid and
//   ready are both 1. The producer holds its payload stable while valid is
//   high and ready is low; ready may depend combinationally on the other
//   side's state but never on valid of the same channel.
// -----------------------------------------------------------------------------
interface pipelined_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] C;
    logic             Cout;
    logic             Ovf;
    logic             Zero;

    modport master (
        output in_valid, A, B, Cin, Sub, out_ready,
        input  in_ready, out_valid, C, Cout, Ovf, Zero
    );

    modport slave (
        input  in_valid, A, B, Cin, Sub, out_ready,
        output in_ready, out_valid, C, Cout, Ovf, Zero
    );
endinterface

// File: rtl/addsub_slice.sv
// -----------------------------------------------------------------------------
// addsub_slice
//   Combinational SW-bit adder slice.
//   a, b   : slice operands (b already inverted for subtraction)
//   ci     : carry into the slice
//   s      : slice sum
//   co     : carry out of the slice MSB
//   msb_ci : carry into the slice MSB (with co gives signed overflow)
// -----------------------------------------------------------------------------
module addsub_slice #(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          ci,
    output logic [SW-1:0] s,
    output logic          co,
    output logic          msb_ci
);
    logic [SW:0] sum;

    always_comb begin
        sum    = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, ci};
        s      = sum[SW-1:0];
        co     = sum[SW];
        // The sum bit at the MSB is a ^ b ^ carry-in, so the carry-in falls out.
        msb_ci = a[SW-1] ^ b[SW-1] ^ sum[SW-1];
    end
endmodule

// File: rtl/pipelined_addsub.sv
// -----------------------------------------------------------------------------
// pipelined_addsub
//   WIDTH-bit add/subtract split into STAGES slices, one slice resolved per
//   stage, carry registered between stages. Latency STAGES, throughput 1/cycle.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of pipelined_addsub_if (operands in, result out)
//
//   Subtraction is A + ~B + ~Cin; the raw carry is inverted to give a borrow.
//   Stage boundary k carries: valid, a merged word x (slices below k already
//   hold result bits, slices k and up still hold operand A), the effective B,
//   the running carry and the Sub bit. The last stage writes the output
//   register (C plus flags). The whole pipe moves only when the output
//   register is empty or being drained.
// -----------------------------------------------------------------------------
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    pipelined_addsub_if.slave       bus
);
    localparam int SW = slice_w(WIDTH, STAGES);

    if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_param_check
        $error("pipelined_addsub: WIDTH must be a positive multiple of STAGES");
    end

    logic          advance;
    logic          out_valid_q;
    logic [WIDTH-1:0] c_q;
    addsub_flags_t flags_q;

    // Stage-boundary signals; index k is the input of stage k.
    logic             vld_b [STAGES];
    logic [WIDTH-1:0] x_b   [STAGES];
    logic [WIDTH-1:0] b_b   [STAGES];
    logic             cy_b  [STAGES];
    logic             sub_b [STAGES];

    assign advance      = ~out_valid_q | bus.out_ready;
    assign bus.in_ready = advance;

    assign vld_b[0] = bus.in_valid;
    assign x_b[0]   = bus.A;
    assign b_b[0]   = (bus.Sub == OP_SUB) ? ~bus.B   : bus.B;
    assign cy_b[0]  = (bus.Sub == OP_SUB) ? ~bus.Cin : bus.Cin;
    assign sub_b[0] = bus.Sub;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SW-1:0] s;
        logic          co;
        logic          msb_ci;

        addsub_slice #(.SW(SW)) u_slice (
            .a      (x_b[k][k*SW +: SW]),
            .b      (b_b[k][k*SW +: SW]),
            .ci     (cy_b[k]),
            .s      (s),
            .co     (co),
            .msb_ci (msb_ci)
        );

        if (k < STAGES - 1) begin : g_mid
            logic             vld_d, vld_q;
            logic [WIDTH-1:0] x_d, x_q;
            logic [WIDTH-1:0] b_d, b_q;
            logic             cy_d, cy_q;
            logic             sub_d, sub_q;
            logic             unused_msb_ci;

            assign unused_msb_ci = msb_ci;

            always_comb begin
                vld_d            = vld_b[k];
                x_d              = x_b[k];
                x_d[k*SW +: SW]  = s;
                b_d              = b_b[k];
                cy_d             = co;
                sub_d            = sub_b[k];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= 1'b0;
                    x_q   <= '0;
                    b_q   <= '0;
                    cy_q  <= 1'b0;
                    sub_q <= 1'b0;
                end else if (advance) begin
                    vld_q <= vld_d;
                    x_q   <= x_d;
                    b_q   <= b_d;
                    cy_q  <= cy_d;
                    sub_q <= sub_d;
                end
            end

            assign vld_b[k+1] = vld_q;
            assign x_b[k+1]   = x_q;
            assign b_b[k+1]   = b_q;
            assign cy_b[k+1]  = cy_q;
            assign sub_b[k+1] = sub_q;
        end else begin : g_last
            logic          out_valid_d;
            logic [WIDTH-1:0] c_d;
            addsub_flags_t flags_d;
            logic          unused_b;

            // Only the top slice of B is consumed here.
            assign unused_b = ^b_b[k];

            always_comb begin
                out_valid_d      = vld_b[k];
                c_d              = x_b[k];
                c_d[k*SW +: SW]  = s;
                flags_d.cout     = sub_b[k] ? ~co : co;
                // Same as (A_msb ~^ Beff_msb) & (C_msb ^ A_msb).
                flags_d.ovf      = msb_ci ^ co;
                flags_d.zero     = (c_d == '0);
            end

            // Data is captured only with a valid op so the outputs hold their
            // last result across bubbles.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_valid_q <= 1'b0;
                    c_q         <= '0;
                    flags_q     <= '0;
                end else if (advance) begin
                    out_valid_q <= out_valid_d;
                    if (out_valid_d) begin
                        c_q     <= c_d;
                        flags_q <= flags_d;
                    end
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.C         = c_q;
    assign bus.Cout      = flags_q.cout;
    assign bus.Ovf       = flags_q.ovf;
    assign bus.Zero      = flags_q.zero;
endmodule

// File: tb/tb_pipelined_addsub.sv
// -----------------------------------------------------------------------------
// tb_pipelined_addsub
//   Drives two instances: WIDTH=8/STAGES=2 (directed vector table plus random
//   ops) and WIDTH=32/STAGES=4 (reset mid-stream, backpressure, throughput).
//   A per-instance monitor keeps an expected queue built from an arithmetic
//   reference model and checks every emitted result.
//   Inputs change 1 time unit after the rising edge; outputs are sampled on
//   the falling edge.
// -----------------------------------------------------------------------------
module tb_pipelined_addsub;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_addsub_if #(.WIDTH(8))  bus8 ();
    pipelined_addsub_if #(.WIDTH(32)) bus32 ();

    pipelined_addsub #(.WIDTH(8), .STAGES(2)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input string msg);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
    endtask

    // ---------------- reference model ----------------
    // Returns {cout, ovf, zero, c[31:0]} computed with plain integer arithmetic.
    function automatic logic [34:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        longint lim, ua, ub, sa, sb, ur, sr;
        logic [31:0] mask, c;
        logic cout, ovf;
        lim  = longint'(1) << w;
        mask = 32'(lim - 1);
        ua   = longint'(a & mask);
        ub   = longint'(b & mask);
        sa   = a[w-1] ? ua - lim : ua;
        sb   = b[w-1] ? ub - lim : ub;
        if (sub) begin
            ur   = ua - ub - longint'(cin);
            sr   = sa - sb - longint'(cin);
            cout = (ur < 0);
        end else begin
            ur   = ua + ub + longint'(cin);
            sr   = sa + sb + longint'(cin);
            cout = (ur >= lim);
        end
        c   = 32'(ur) & mask;
        ovf = (sr >= lim / 2) || (sr < -(lim / 2));
        return {cout, ovf, (c == 32'd0), c};
    endfunction

    // ---------------- scoreboards ----------------
    logic [34:0] exp8_q[$];
    int          acc8_q[$];
    int          emit8_n = 0;

    always @(negedge clk) begin : mon8
        logic [34:0] e;
        int ac;
        if (rst) begin
            exp8_q.delete();
            acc8_q.delete();
        end else begin
            check("in_ready8_rule", bus8.in_ready, !bus8.out_valid || bus8.out_ready);
            if (bus8.out_valid && bus8.out_ready) begin
                emit8_n++;
                if (exp8_q.size() == 0) begin
                    fail_now("emit8_unexpected", "result emitted with nothing in flight");
                end else begin
                    e  = exp8_q.pop_front();
                    ac = acc8_q.pop_front();
                    check("c8", bus8.C, e[7:0]);
                    check("flags8", {bus8.Cout, bus8.Ovf, bus8.Zero}, e[34:32]);
                    check("latency8", cyc - ac, 2);
                end
            end
            if (bus8.in_valid && bus8.in_ready) begin
                exp8_q.push_back(model(8, {24'd0, bus8.A}, {24'd0, bus8.B}, bus8.Cin, bus8.Sub));
                acc8_q.push_back(cyc);
            end
        end
    end

    logic [34:0] exp32_q[$];
    int          acc32_q[$];
    int          emit32_cyc_q[$];
    int          emit32_n   = 0;
    logic        lat32_chk  = 1'b0;
    logic        stall32_prev = 1'b0;
    logic [34:0] out32_prev;

    always @(negedge clk) begin : mon32
        logic [34:0] e;
        int ac;
        if (rst) begin
            exp32_q.delete();
            acc32_q.delete();
            stall32_prev = 1'b0;
        end else begin
            check("in_ready32_rule", bus32.in_ready, !bus32.out_valid || bus32.out_ready);
            if (stall32_prev) begin
                check("stall_valid32", bus32.out_valid, 1'b1);
                check("stall_hold32", {bus32.Cout, bus32.Ovf, bus32.Zero, bus32.C}, out32_prev);
            end
            if (bus32.out_valid && bus32.out_ready) begin
                emit32_n++;
                emit32_cyc_q.push_back(cyc);
                if (exp32_q.size() == 0) begin
                    fail_now("emit32_unexpected", "result emitted with nothing in flight");
                end else begin
                    e  = exp32_q.pop_front();
                    ac = acc32_q.pop_front();
                    check("c32", bus32.C, e[31:0]);
                    check("flags32", {bus32.Cout, bus32.Ovf, bus32.Zero}, e[34:32]);
                    if (lat32_chk) check("latency32", cyc - ac, 4);
                end
            end
            if (bus32.in_valid && bus32.in_ready) begin
                exp32_q.push_back(model(32, bus32.A, bus32.B, bus32.Cin, bus32.Sub));
                acc32_q.push_back(cyc);
            end
            stall32_prev = bus32.out_valid && !bus32.out_ready;
            out32_prev   = {bus32.Cout, bus32.Ovf, bus32.Zero, bus32.C};
        end
    end

    // ---------------- drivers (call at posedge + 1) ----------------
    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
        int w = 0;
        bus8.in_valid = 1'b1;
        bus8.A = a; bus8.B = b; bus8.Cin = cin; bus8.Sub = sub;
        @(negedge clk);
        while (!bus8.in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) fail_now("send8_timeout", "in_ready never asserted");
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
    endtask

    task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        int w = 0;
        bus32.in_valid = 1'b1;
        bus32.A = a; bus32.B = b; bus32.Cin = cin; bus32.Sub = sub;
        @(negedge clk);
        while (!bus32.in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) fail_now("send32_timeout", "in_ready never asserted");
        @(posedge clk);
        #1;
        bus32.in_valid = 1'b0;
    endtask

    task automatic drain32(input string name);
        int w = 0;
        while (exp32_q.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (exp32_q.size() != 0) fail_now(name, "pipeline did not drain");
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vectors (WIDTH=8) ----------------
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] c;
        logic       cout;
        logic       ovf;
        logic       zero;
    } vec_t;

    vec_t vecs[8];

    // Watchdog: the run never needs more than a few thousand cycles.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int emit_before;
        logic done;

        vecs[0] = '{8'd4,   8'd5,   1'b1, 1'b0, 8'd10,  1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'hFF,  8'h01,  1'b0, 1'b0, 8'h00,  1'b1, 1'b0, 1'b1};
        vecs[2] = '{8'h7F,  8'h01,  1'b0, 1'b0, 8'h80,  1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'd10,  8'd11,  1'b0, 1'b1, 8'hFF,  1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h80,  8'h01,  1'b0, 1'b1, 8'h7F,  1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'h05,  8'h05,  1'b0, 1'b1, 8'h00,  1'b0, 1'b0, 1'b1};
        vecs[6] = '{8'h00,  8'h00,  1'b1, 1'b1, 8'hFF,  1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'h80,  8'h80,  1'b0, 1'b0, 8'h00,  1'b1, 1'b1, 1'b1};

        rst = 1'b1;
        bus8.in_valid  = 1'b0; bus8.A  = '0; bus8.B  = '0; bus8.Cin  = 1'b0; bus8.Sub  = 1'b0;
        bus8.out_ready = 1'b1;
        bus32.in_valid = 1'b0; bus32.A = '0; bus32.B = '0; bus32.Cin = 1'b0; bus32.Sub = 1'b0;
        bus32.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid8", bus8.out_valid, 1'b0);
        check("reset_c8", bus8.C, 8'd0);
        check("reset_out_valid32", bus32.out_valid, 1'b0);
        check("reset_c32", {bus32.Cout, bus32.Ovf, bus32.Zero, bus32.C}, 35'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ---- reset with two ops in flight (defaults) ----
        bus32.out_ready = 1'b0;
        send32(32'h1234_5678, 32'h0000_0001, 1'b0, 1'b0);
        send32(32'h0000_00FF, 32'h0000_0100, 1'b1, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus32.out_valid && n < 20);
        check("rst_pre_valid32", bus32.out_valid, 1'b1);
        check("rst_pre_c32", bus32.C, 32'h1234_5679);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_async_valid32", bus32.out_valid, 1'b0);
        check("rst_async_out32", {bus32.Cout, bus32.Ovf, bus32.Zero, bus32.C}, 35'd0);
        @(posedge clk);
        #1;
        bus32.out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        emit_before = emit32_n;
        repeat (12) @(posedge clk);
        #1;
        check("rst_nothing_emitted32", emit32_n - emit_before, 0);

        // ---- directed table (WIDTH=8, STAGES=2) ----
        for (int i = 0; i < 8; i++) begin
            send8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus8.out_valid && n < 10);
            if (!bus8.out_valid) begin
                fail_now($sformatf("vec%0d_timeout", i), "no result");
            end else begin
                check($sformatf("vec%0d_c", i), bus8.C, vecs[i].c);
                check($sformatf("vec%0d_cout", i), bus8.Cout, vecs[i].cout);
                check($sformatf("vec%0d_ovf", i), bus8.Ovf, vecs[i].ovf);
                check($sformatf("vec%0d_zero", i), bus8.Zero, vecs[i].zero);
                check($sformatf("vec%0d_latency", i), n, 2);
            end
            @(posedge clk);
            #1;
        end

        // ---- random back-to-back ops (WIDTH=8) ----
        emit_before = emit8_n;
        for (int i = 0; i < 30; i++) begin
            send8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        repeat (6) @(posedge clk);
        #1;
        check("rand8_count", emit8_n - emit_before, 30);

        // ---- backpressure (defaults) ----
        emit_before = emit32_n;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    send32($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    bus32.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus32.out_ready = 1'b1;
        drain32("bp_drain32");
        check("bp_count32", emit32_n - emit_before, 10);

        // ---- throughput / latency (defaults) ----
        emit32_cyc_q.delete();
        lat32_chk = 1'b1;
        for (int i = 0; i < 100; i++) begin
            send32($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain32("tp_drain32");
        lat32_chk = 1'b0;
        check("tp_count32", emit32_cyc_q.size(), 100);
        if (emit32_cyc_q.size() == 100)
            check("tp_no_gaps32", emit32_cyc_q[99] - emit32_cyc_q[0], 99);

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("leftover8", exp8_q.size(), 0);
        check("leftover32", exp32_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
